// File: rtl/decoder_2_4_stream_pkg.sv
// Shared types and helpers for the 2:4 decoder stream link.
// Holds the skid-buffer state encoding and the word decode helper.
package decoder_2_4_stream_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } skid_state_t;

   localparam int DEC_CODE_W = 2;
   localparam int DEC_OH_W   = 2 ** DEC_CODE_W;

   // {invalid, onehot} for the default 2-bit code width
   function automatic logic [DEC_OH_W:0] dec_word(
      input logic [DEC_CODE_W-1:0] code,
      input logic                  invalid
   );
      logic [DEC_OH_W-1:0] oh;
      oh = '0;
      if (!invalid) begin
         oh[code] = 1'b1;
      end
      return {invalid, oh};
   endfunction

endpackage

// File: rtl/decoder_2_4_skid.sv
// Generic 2-entry valid/ready skid buffer.
// Output register drives out_*; skid register absorbs one stalled word.
module decoder_2_4_skid
   import decoder_2_4_stream_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_t  state_q, state_d;
   logic [W-1:0] or_q, or_d;
   logic [W-1:0] sr_q, sr_d;
   logic         in_ready_q, in_ready_d;
   logic         acc, xfer;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != S_EMPTY);
   assign out_data  = or_q;
   assign acc       = in_valid & in_ready_q;
   assign xfer      = out_valid & out_ready;

   // Next-state and storage moves; in_ready is registered from next state
   always_comb begin
      state_d = state_q;
      or_d    = or_q;
      sr_d    = sr_q;
      unique case (state_q)
         S_EMPTY: begin
            if (acc) begin
               or_d    = in_data;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (acc && !xfer) begin
               sr_d    = in_data;
               state_d = S_FULL;
            end else if (acc && xfer) begin
               or_d = in_data;
            end else if (xfer) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (xfer) begin
               or_d    = sr_q;
               state_d = S_ONE;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
      in_ready_d = (state_d != S_FULL);
   end

   // State, storage and ready registers; reset drops any buffered words
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         or_q       <= '0;
         sr_q       <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         or_q       <= or_d;
         sr_q       <= sr_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule

// File: rtl/decoder_2_4_stream.sv
// Receive side of the encoder link: decodes {invalid, code} to one-hot,
// buffers through a skid stage and counts invalid words.
module decoder_2_4_stream
   import decoder_2_4_stream_pkg::*;
#(
   parameter int CODE_W = 2,
   parameter int ERR_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CODE_W:0]      in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2**CODE_W-1:0] out_onehot,
   output logic                 out_invalid,
   input  logic                 err_clr,
   output logic [ERR_W-1:0]     err_count
);

   localparam int OH_W = 2 ** CODE_W;
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   logic [OH_W:0]      dec_w;
   logic [OH_W:0]      skid_out;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               acc;
   logic               bad;

   assign bad = in_data[CODE_W];
   assign acc = in_valid & in_ready;

   // Decode the incoming word; code bits are ignored when flagged invalid
   always_comb begin
      dec_w = '0;
      dec_w[OH_W] = bad;
      if (!bad) begin
         dec_w[in_data[CODE_W-1:0]] = 1'b1;
      end
   end

   decoder_2_4_skid #(
      .W (OH_W + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (dec_w),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (skid_out)
   );

   assign out_onehot  = skid_out[OH_W-1:0];
   assign out_invalid = skid_out[OH_W];
   assign err_count   = err_q;

   // Saturating invalid-word count, taken at accept; clear wins
   always_comb begin
      err_d = err_q;
      if (err_clr) begin
         err_d = '0;
      end else if (acc && bad && (err_q != ERR_MAX)) begin
         err_d = err_q + 1'b1;
      end
   end

   // Error counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_decoder_2_4_stream.sv
// Self-checking bench for decoder_2_4_stream.
// Reference model: FIFO queue of expected words plus an integer counter.
module tb_decoder_2_4_stream;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_onehot;
   logic       out_invalid;
   logic       err_clr;
   logic [7:0] err_count;

   int n_chk;
   int n_pass;

   logic [4:0] q[$];
   int         err_m;

   decoder_2_4_stream #(
      .CODE_W (2),
      .ERR_W  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_onehot  (out_onehot),
      .out_invalid (out_invalid),
      .err_clr     (err_clr),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [4:0] model(input logic [2:0] d);
      int oh;
      if (d[2]) return 5'b10000;
      oh = 2 ** int'(d[1:0]);
      return {1'b0, oh[3:0]};
   endfunction

   task automatic cyc(input logic v, input logic [2:0] d,
                      input logic ordy, input logic clr);
      logic acc;
      logic xfr;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      err_clr   = clr;
      #1;
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("out_onehot", out_onehot, q[0][3:0]);
         chk("out_invalid", out_invalid, q[0][4]);
      end
      chk("err_count", err_count, err_m);
      acc = v && (q.size() < 2);
      xfr = (q.size() > 0) && ordy;
      @(posedge clk);
      if (xfr) void'(q.pop_front());
      if (acc) q.push_back(model(d));
      if (clr) err_m = 0;
      else if (acc && d[2] && err_m < 255) err_m++;
   endtask

   task automatic model_reset();
      q.delete();
      err_m = 0;
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      err_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_onehot", out_onehot, 0);
      chk("rst_invalid", out_invalid, 0);
      chk("rst_err", err_count, 0);
      @(negedge clk);
      rst = 1'b0;

      // single word
      cyc(1, 3'b010, 1, 0);
      cyc(0, 3'b000, 1, 0);

      // back-to-back stream
      cyc(1, 3'b000, 1, 0);
      cyc(1, 3'b001, 1, 0);
      cyc(1, 3'b011, 1, 0);
      cyc(0, 3'b000, 1, 0);
      cyc(0, 3'b000, 1, 0);

      // stall fills the skid, third word held off
      cyc(1, 3'b000, 0, 0);
      cyc(1, 3'b001, 0, 0);
      cyc(1, 3'b011, 0, 0);
      #1 chk("stall_in_ready", in_ready, 0);
      cyc(0, 3'b000, 1, 0);
      cyc(0, 3'b000, 1, 0);
      cyc(0, 3'b000, 1, 0);

      // invalid words and saturation
      cyc(1, 3'b110, 1, 0);
      cyc(0, 3'b000, 1, 0);
      #1 chk("err_one", err_count, 1);
      for (int i = 0; i < 300; i++) begin
         cyc(1, {1'b1, 2'($urandom)}, 1, 0);
      end
      cyc(0, 3'b000, 1, 0);
      #1 chk("err_sat", err_count, 255);

      // clear coinciding with invalid accept
      cyc(1, 3'b100, 1, 1);
      cyc(0, 3'b000, 1, 0);
      cyc(0, 3'b000, 1, 0);
      #1 chk("err_clr", err_count, 0);

      // async reset while full
      cyc(1, 3'b001, 0, 0);
      cyc(1, 3'b010, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_onehot", out_onehot, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 3'b011, 0, 0);
      cyc(0, 3'b000, 1, 0);
      cyc(0, 3'b000, 1, 0);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         cyc($urandom_range(0, 3) != 0, 3'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 3'b000, 1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
